uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, line bit rate in bit/s.
REQ-003 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-004 Parameter FIFO_DEPTH, default 16, transmit FIFO entries; power of two, at least 2.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 tx_data  input  DATA_BITS  word to enqueue.
REQ-008 tx_valid  input  1  tx_data is valid this cycle.
REQ-009 tx_ready  output  1  FIFO can accept a word; a write occurs on a rising edge with tx_valid=1 and tx_ready=1.
REQ-010 parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-011 stop2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-012 uart_tx_pin  output  1  serial line; idle high.
REQ-013 tx_busy  output  1  a frame is in progress.
REQ-014 tx_done  output  1  one-cycle pulse at the end of each frame.
REQ-015 fifo_count  output  clog2(FIFO_DEPTH)+1  number of words queued, excluding the frame in flight.

Function
REQ-016 Each line bit SHALL last exactly CLK_FREQ/BAUD_RATE clocks, using integer division.
REQ-017 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-018 State sequence: IDLE -> START -> DATA (DATA_BITS bits, LSB first) -> PARITY (only if parity_mode is 01 or 10) -> STOP (1 or 2 bit periods) -> IDLE or START.
REQ-019 In IDLE with fifo_count>0, the block SHALL pop the head word, latch parity_mode and stop2, and enter START; uart_tx_pin goes low on the same edge.
REQ-020 A word written at edge E into an empty FIFO while IDLE SHALL drive the start bit low at edge E+2.
REQ-021 Line levels: START=0; DATA = latched word bit[i]; PARITY = XOR of data bits for even, its inverse for odd; STOP=1.
REQ-022 Changes on parity_mode, stop2 or tx_data during a frame SHALL NOT affect that frame.
REQ-023 At the end of STOP with fifo_count>0, the next START SHALL begin on the same edge, with no idle clock between frames.
REQ-024 At the end of STOP with fifo_count=0, the FSM SHALL return to IDLE and hold the line high.
REQ-025 tx_done SHALL be 1 for exactly the clock after the last stop period completes.
REQ-026 tx_busy SHALL be 1 whenever the state is not IDLE.
REQ-027 tx_ready SHALL equal (fifo_count < FIFO_DEPTH), registered.
REQ-028 When full, writes SHALL be refused even if a pop occurs in the same cycle.
REQ-029 A simultaneous push and pop SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 A pop SHALL never occur on an empty FIFO.
REQ-032 An accepted word SHALL never be dropped or duplicated.

Reset
REQ-033 While rst=1 at a rising edge, the next state SHALL be: uart_tx_pin=1, tx_busy=0, tx_done=0, tx_ready=1, fifo_count=0, FSM=IDLE, baud counter=0, FIFO emptied.
REQ-034 Reset asserted mid-frame SHALL abort the frame immediately; the partial frame is not resumed and FIFO contents are discarded.
REQ-035 After rst deasserts, the line SHALL stay high until a new word is written.

Verification (CLK_FREQ=1000, BAUD_RATE=100, so 10 clocks per bit, FIFO_DEPTH=16)
REQ-036 8N1, write 0xA5 -> line shows 0, then 1,0,1,0,0,1,0,1, then 1, each for 10 clocks; frame is 100 clocks; one tx_done pulse; tx_busy high for 100 clocks.
REQ-037 Write 0x07 with parity_mode=01 -> parity bit 1; with 10 -> parity bit 0; with stop2=1 -> frame is 120 clocks.
REQ-038 Write 17 words back-to-back while busy -> tx_ready falls when fifo_count=16 and the 17th word is held off; all words are sent in order, each start bit immediately follows the previous stop bit.
REQ-039 DATA_BITS=9, write 0x1FF with even parity -> nine 1 bits, then parity 1.
REQ-040 Assert rst during DATA with 3 words queued -> next edge: line 1, busy 0, fifo_count 0, tx_ready 1; no further line activity.
REQ-041 Toggle parity_mode and stop2 mid-frame -> the current frame keeps the settings latched at its START; the next frame uses the new settings.

Source files
------------

// File: rtl/uart_tx_param.sv
// UART transmitter with a FIFO in front of it. Frame settings are latched per frame at START.
// Start bit appears two edges after a write into an empty idle FIFO; tx_ready deasserts when full.
module uart_tx_param #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  output logic                          uart_tx_pin,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int BIT_CLKS = CLK_FREQ / BAUD_RATE;
  localparam int CW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q, count_d;
  logic                 ready_q, avail_q;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d, par_en_q, par_en_d, stop2_q, stop2_d;
  logic                 stop_sec_q, stop_sec_d, pin_q, pin_d, done_q, done_d;
  logic                 bit_end, launch;

  assign push = tx_valid && ready_q;
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!push && pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  // avail_q delays the idle launch by one clock so the start bit lands at write edge + 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      avail_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ready_q <= (count_d != FULL_CNT);
      avail_q <= (count_q != '0);
    end
  end

  assign bit_end = (cnt_q == CW'(BIT_CLKS-1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = bit_end ? '0 : cnt_q + CW'(1);
    bit_d      = bit_q;
    sh_d       = sh_q;
    par_d      = par_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    stop_sec_d = stop_sec_q;
    pin_d      = pin_q;
    done_d     = 1'b0;
    launch     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        pin_d = 1'b1;
        if (avail_q && count_q != '0) launch = 1'b1;
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = '0;
        pin_d   = sh_q[0];
      end
      DATA: if (bit_end) begin
        if (bit_q == BW'(DATA_BITS-1)) begin
          state_d    = par_en_q ? PARITY : STOP;
          pin_d      = par_en_q ? par_q : 1'b1;
          stop_sec_d = 1'b0;
        end else begin
          bit_d = bit_q + BW'(1);
          sh_d  = sh_q >> 1;
          pin_d = sh_q[1];
        end
      end
      PARITY: if (bit_end) begin
        state_d    = STOP;
        pin_d      = 1'b1;
        stop_sec_d = 1'b0;
      end
      STOP: if (bit_end) begin
        if (stop2_q && !stop_sec_q) begin
          stop_sec_d = 1'b1;
        end else begin
          done_d = 1'b1;
          if (count_q != '0) launch = 1'b1;
          else begin
            state_d = IDLE;
            pin_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (launch) begin
      state_d  = START;
      cnt_d    = '0;
      pin_d    = 1'b0;
      sh_d     = head;
      par_d    = (^head) ^ (parity_mode == 2'b10);
      par_en_d = parity_mode[0] ^ parity_mode[1];
      stop2_d  = stop2;
    end
  end

  assign pop = launch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      par_q      <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      stop_sec_q <= 1'b0;
      pin_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      par_q      <= par_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      stop_sec_q <= stop_sec_d;
      pin_q      <= pin_d;
      done_q     <= done_d;
    end
  end

  assign uart_tx_pin = pin_q;
  assign tx_busy     = (state_q != IDLE);
  assign tx_done     = done_q;
  assign tx_ready    = ready_q;
  assign fifo_count  = count_q;
endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: 10 clocks per bit, one 8-bit and one 9-bit instance.
module tb_uart_tx_param;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data8;
  logic       tx_valid8, ready8, pin8, busy8, done8, stop2_8;
  logic [1:0] parity8;
  logic [4:0] count8;
  logic [8:0] tx_data9;
  logic       tx_valid9, ready9, pin9, busy9, done9, stop2_9;
  logic [1:0] parity9;
  logic [4:0] count9;
  logic       cur_sel, cur_pin, cur_busy, cur_done;
  int         nassert = 0;
  int         nfail = 0;
  logic [7:0] words [18];

  always #5 clk = ~clk;

  uart_tx_param #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .FIFO_DEPTH(16)) u8 (
    .clk(clk), .rst(rst), .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(ready8),
    .parity_mode(parity8), .stop2(stop2_8), .uart_tx_pin(pin8), .tx_busy(busy8),
    .tx_done(done8), .fifo_count(count8));

  uart_tx_param #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(9), .FIFO_DEPTH(16)) u9 (
    .clk(clk), .rst(rst), .tx_data(tx_data9), .tx_valid(tx_valid9), .tx_ready(ready9),
    .parity_mode(parity9), .stop2(stop2_9), .uart_tx_pin(pin9), .tx_busy(busy9),
    .tx_done(done9), .fifo_count(count9));

  assign cur_pin  = cur_sel ? pin9  : pin8;
  assign cur_busy = cur_sel ? busy9 : busy8;
  assign cur_done = cur_sel ? done9 : done8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write happens on the following posedge.
  task automatic push8(input logic [7:0] w);
    tx_valid8 = 1'b1;
    tx_data8  = w;
    @(posedge clk);
    @(negedge clk);
    tx_valid8 = 1'b0;
  endtask

  task automatic wait_start();
    int g = 0;
    while (cur_pin !== 1'b0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("start_found", 32'(cur_pin), 32'(1'b0));
  endtask

  // Entered at the negedge inside the first start-bit clock; leaves at the tx_done clock.
  task automatic expect_frame(input logic [8:0] w, input int nb, input logic pen,
                              input logic pval, input int nstop);
    logic [15:0] line;
    int nl;
    line = '0;
    nl = 0;
    line[nl] = 1'b0; nl++;
    for (int i = 0; i < nb; i++) begin line[nl] = w[i]; nl++; end
    if (pen) begin line[nl] = pval; nl++; end
    for (int i = 0; i < nstop; i++) begin line[nl] = 1'b1; nl++; end
    for (int k = 0; k < nl * 10; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) chk("frame_start", 32'({cur_pin, cur_busy}), 32'(2'b01));
      else chk("frame_bit", 32'({cur_pin, cur_busy, cur_done}), 32'({line[k/10], 2'b10}));
    end
    @(negedge clk);
    chk("done_pulse", 32'(cur_done), 32'(1'b1));
  endtask

  initial begin
    cur_sel = 1'b0;
    rst = 1'b1;
    tx_data8 = '0; tx_valid8 = 1'b0; parity8 = 2'b00; stop2_8 = 1'b0;
    tx_data9 = '0; tx_valid9 = 1'b0; parity9 = 2'b01; stop2_9 = 1'b0;
    for (int i = 0; i < 18; i++) words[i] = 8'(8'h11 + i * 23);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_state8", 32'({pin8, busy8, done8, ready8, count8}), 32'({4'b1001, 5'd0}));
    chk("rst_state9", 32'({pin9, busy9, done9, ready9, count9}), 32'({4'b1001, 5'd0}));

    // 8N1 0xA5 with start-bit latency
    tx_valid8 = 1'b1; tx_data8 = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    tx_valid8 = 1'b0;
    chk("lat_e1", 32'(pin8), 32'(1'b1));
    @(negedge clk);
    chk("lat_e2", 32'(pin8), 32'(1'b1));
    @(negedge clk);
    chk("lat_start", 32'(pin8), 32'(1'b0));
    expect_frame(9'h0A5, 8, 1'b0, 1'b0, 1);
    chk("idle_after", 32'(busy8), 32'(1'b0));
    @(negedge clk);
    chk("done_one_clk", 32'({done8, pin8}), 32'(2'b01));

    // parity and two-stop frames of 0x07
    parity8 = 2'b01;
    push8(8'h07); wait_start(); expect_frame(9'h007, 8, 1'b1, 1'b1, 1);
    parity8 = 2'b10;
    push8(8'h07); wait_start(); expect_frame(9'h007, 8, 1'b1, 1'b0, 1);
    parity8 = 2'b00; stop2_8 = 1'b1;
    push8(8'h07); wait_start(); expect_frame(9'h007, 8, 1'b0, 1'b0, 2);
    stop2_8 = 1'b0;
    @(negedge clk);

    // 18 back-to-back writes: 16 fill the FIFO behind the frame in flight, the 18th is held off
    fork
      begin
        for (int i = 0; i < 18; i++) begin
          logic acc;
          int g;
          tx_valid8 = 1'b1;
          tx_data8  = words[i];
          acc = 1'b0;
          g = 0;
          while (!acc && g < 500) begin
            acc = ready8;
            @(posedge clk);
            @(negedge clk);
            g++;
          end
          chk("push_accept", 32'(acc), 32'(1'b1));
          if (i == 16) begin
            chk("full_count", 32'(count8), 32'(16));
            chk("full_ready", 32'(ready8), 32'(1'b0));
          end
          if (i == 17) chk("held_off", 32'(g > 50), 32'(1'b1));
        end
        tx_valid8 = 1'b0;
      end
      begin
        wait_start();
        for (int i = 0; i < 18; i++) expect_frame({1'b0, words[i]}, 8, 1'b0, 1'b0, 1);
        chk("burst_idle", 32'({busy8, count8}), 32'(0));
      end
    join
    @(negedge clk);

    // settings changed mid-frame apply only to the next frame
    parity8 = 2'b01; stop2_8 = 1'b0;
    push8(8'h07);
    push8(8'h3C);
    wait_start();
    fork
      begin
        repeat (30) @(negedge clk);
        parity8 = 2'b10;
        stop2_8 = 1'b1;
      end
    join_none
    expect_frame(9'h007, 8, 1'b1, 1'b1, 1);
    expect_frame(9'h03C, 8, 1'b1, 1'b1, 2);
    parity8 = 2'b00; stop2_8 = 1'b0;
    @(negedge clk);

    // nine data bits, even parity
    cur_sel = 1'b1;
    tx_valid9 = 1'b1; tx_data9 = 9'h1FF;
    @(posedge clk);
    @(negedge clk);
    tx_valid9 = 1'b0;
    wait_start();
    expect_frame(9'h1FF, 9, 1'b1, 1'b1, 1);
    cur_sel = 1'b0;
    @(negedge clk);

    // reset mid-frame with three words queued
    push8(8'h55); push8(8'h66); push8(8'h77); push8(8'h88);
    wait_start();
    repeat (20) @(negedge clk);
    chk("pre_rst_count", 32'(count8), 32'(3));
    chk("pre_rst_busy", 32'(busy8), 32'(1'b1));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_frame", 32'({pin8, busy8, done8, ready8, count8}), 32'({4'b1001, 5'd0}));
    begin
      logic saw;
      saw = 1'b0;
      repeat (300) begin
        @(negedge clk);
        if (pin8 !== 1'b1 || busy8 !== 1'b0) saw = 1'b1;
      end
      chk("quiet_after_rst", 32'(saw), 32'(1'b0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
